// File: rtl/pipeline_rr_scheduler.sv
// pipeline_rr_scheduler
// Round-robin front end for a shared fixed-latency, non-stalling pipeline.
// One request is issued per cycle; a tag shift register that runs in lockstep
// with the pipeline remembers which requester owns each in-flight item, so the
// result emerging at pipe_out_data can be steered back to its owner. A small
// per-requester credit counter caps outstanding work.
module pipeline_rr_scheduler #(
  parameter int NREQ         = 4,
  parameter int W            = 32,
  parameter int LATENCY      = 3,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              pipe_in_valid,
  output logic [W-1:0]      pipe_in_data,
  input  logic [W-1:0]      pipe_out_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(MAX_INFLIGHT);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ - 1);
  localparam logic [ID_W:0]   NREQ_EXT = (ID_W + 1)'(NREQ);

  // Credit update: one issue and one return in the same cycle cancel out.
  // The guards keep the counter inside 0..MAX_INFLIGHT even if the
  // caller ever presents an impossible combination.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          inc,
                                                input logic          dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != CRED_MAX)) begin
      nxt = cur + CW'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - CW'(1);
    end
    return nxt;
  endfunction

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            issue;
  logic [NREQ-1:0] elig;
  logic [ID_W:0]   scan_pos;
  logic [ID_W-1:0] scan_id;
  logic [CW-1:0]   inflight [NREQ];

  // Tag pipe: index k is the stage k register; the last stage lines up
  // with pipe_out_data.
  logic            tag_vld_p [LATENCY];
  logic [ID_W-1:0] tag_id_p  [LATENCY];

  logic            ret_vld;
  logic [ID_W-1:0] ret_id;

  // Eligibility: pending, below credit limit, not flushing, not in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (inflight[i] < CRED_MAX) && !flush && rst_n;
    end
  end

  // Round-robin scan starting at ptr, wrapping modulo NREQ.
  always_comb begin
    issue    = 1'b0;
    winner   = '0;
    scan_pos = '0;
    scan_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_pos = {1'b0, ptr} + (ID_W + 1)'(k);
      if (scan_pos >= NREQ_EXT) begin
        scan_pos = scan_pos - NREQ_EXT;
      end
      scan_id = scan_pos[ID_W-1:0];
      if (!issue && elig[scan_id]) begin
        issue  = 1'b1;
        winner = scan_id;
      end
    end
  end

  // Grant decode and operand mux toward the pipeline input.
  always_comb begin
    req_ready     = '0;
    pipe_in_data  = '0;
    pipe_in_valid = issue;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (winner == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        pipe_in_data = req_data[i*W +: W];
      end
    end
  end

  // Result steering: the oldest tag names the owner of pipe_out_data.
  always_comb begin
    ret_vld   = tag_vld_p[LATENCY-1] && !flush;
    ret_id    = tag_id_p[LATENCY-1];
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = ret_vld && (ret_id == ID_W'(i));
    end
    rsp_data = pipe_out_data;
  end

  // Priority pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end
  end

  // Tag valid bits shift every cycle; flush and reset drop all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_vld_p[k] <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_vld_p[k] <= 1'b0;
      end
    end else begin
      tag_vld_p[0] <= issue;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
      end
    end
  end

  // Tag ids travel beside the valid bits; they are only looked at when valid.
  always_ff @(posedge clk) begin
    tag_id_p[0] <= winner;
    for (int k = 1; k < LATENCY; k++) begin
      tag_id_p[k] <= tag_id_p[k-1];
    end
  end

  // Per-requester in-flight credit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        inflight[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREQ; i++) begin
        inflight[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        inflight[i] <= credit_next(inflight[i],
                                   issue && (winner == ID_W'(i)),
                                   ret_vld && (ret_id == ID_W'(i)));
      end
    end
  end

endmodule
